// File: rtl/uart_boot_loader.sv
`timescale 1ns/1ps
// uart_boot_loader: 8N1 UART frame (A5, LEN_LO, LEN_HI, N x 4 payload bytes) -> sequential imem word writes; core held in reset until loaded.
// Latency: imem_we_o one cycle after the 4th byte of a word; done_o/core_reset_n_o one cycle after the final byte. No backpressure.
// Optional BOOT_CHECKSUM_EN: an XOR-of-payload checksum byte follows the payload and must match.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_reset_n_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_WIDTH;

    // ---------------- receiver ----------------
    logic rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {rx_meta, rx_s, rx_prev} <= 3'b111;
        end else begin
            {rx_meta, rx_s, rx_prev} <= {rx_i, rx_meta, rx_s};
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          bit_end;
    logic          byte_valid;
    logic          frame_err;

    assign bit_end    = (rx_cnt == BIT_END);
    assign byte_valid = (rx_state == RX_STOP) && bit_end && rx_s;
    assign frame_err  = (rx_state == RX_STOP) && bit_end && !rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) rx_state <= RX_START;
                end
                RX_START: begin
                    // a start bit that is high again at mid-bit was a glitch
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- protocol ----------------
`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {WAIT_HDR, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {WAIT_HDR, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
`endif

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] wcnt;
    logic [15:0] wcnt_next;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic        terminal;
    logic        len_too_big;
    logic        payload_done;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign wcnt_next    = wcnt + 16'd1;
    assign terminal     = (state == DONE) || (state == ERROR);
    assign len_too_big  = ({1'b0, rx_shift, len_lo} > MAX_WORDS);
    assign payload_done = byte_valid &&
                          (((state == LEN_HI) && ({rx_shift, len_lo} == 16'd0)) ||
                           ((state == DATA) && (byte_idx == 2'd3) && (wcnt_next == len)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= WAIT_HDR;
            len_lo         <= '0;
            len            <= '0;
            wcnt           <= '0;
            byte_idx       <= '0;
            asm_q          <= '0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= '0;
            imem_wdata_o   <= '0;
            core_reset_n_o <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            imem_we_o <= 1'b0;
            if (imem_we_o) imem_addr_o <= imem_addr_o + ADDR_WIDTH'(1);

            if (frame_err && !terminal) begin
                state <= ERROR;
                err_o <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    WAIT_HDR: if (rx_shift == 8'hA5) state <= LEN_LO;
                    LEN_LO: begin
                        len_lo <= rx_shift;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        len <= {rx_shift, len_lo};
                        if (len_too_big) begin
                            state <= ERROR;
                            err_o <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        asm_q    <= {rx_shift, asm_q[23:8]};
                        byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        csum_q   <= csum_q ^ rx_shift;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we_o    <= 1'b1;
                            imem_wdata_o <= {rx_shift, asm_q};
                            wcnt         <= wcnt_next;
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    CSUM: begin
                        if (rx_shift == csum_q) begin
                            state          <= DONE;
                            done_o         <= 1'b1;
                            core_reset_n_o <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err_o <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase

                // end of payload overrides the LEN_HI/DATA next-state chosen above
                if (payload_done) begin
`ifdef BOOT_CHECKSUM_EN
                    state          <= CSUM;
`else
                    state          <= DONE;
                    done_o         <= 1'b1;
                    core_reset_n_o <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
`timescale 1ns/1ps
// Bench for uart_boot_loader: table of frames with expected writes/flags, plus hand sequences for glitch, latency and reset corners.
module tb_uart_boot_loader;
    localparam int CPB = 16;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_i = 1'b1;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_reset_n_o;
    logic          done_o;
    logic          err_o;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_i           (rx_i),
        .imem_we_o      (imem_we_o),
        .imem_addr_o    (imem_addr_o),
        .imem_wdata_o   (imem_wdata_o),
        .core_reset_n_o (core_reset_n_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_seen = 0;
    logic        prev_we = 1'b0;
    logic [63:0] sb_q[$];

    typedef struct {
        string        name;
        int           nbytes;
        logic [159:0] raw;       // first byte in the most significant used position
        int           bad_idx;   // byte sent with stop bit 0, -1 for none
        int           cs_from;   // checksum covers bytes [cs_from, cs_at)
        int           cs_at;     // checksum inserted before this byte index, -1 for none
        int           nwr;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         exp_done;
        logic         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input int n, input logic [159:0] raw, input int bad,
                       input int cs_from, input int cs_at, input int nwr,
                       input logic [31:0] w0, input logic [31:0] w1, input logic dn, input logic er);
        vec_t v;
        v.name = name; v.nbytes = n; v.raw = raw; v.bad_idx = bad;
        v.cs_from = cs_from; v.cs_at = cs_at; v.nwr = nwr;
        v.w0 = w0; v.w1 = w1; v.exp_done = dn; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        @(posedge clk); #1 rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_i = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_i = stop_val;
        repeat (CPB) @(posedge clk);
        #1 rx_i = 1'b1;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] b;
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00;
`endif
        for (int i = 0; i <= v.nbytes; i++) begin
`ifdef BOOT_CHECKSUM_EN
            if (i == v.cs_at) send_byte(cs, 1'b1);
`endif
            if (i < v.nbytes) begin
                b = v.raw[8*(v.nbytes-1-i) +: 8];
`ifdef BOOT_CHECKSUM_EN
                if (v.cs_from >= 0 && i >= v.cs_from && i < v.cs_at) cs = cs ^ b;
`endif
                send_byte(b, (i != v.bad_idx));
            end
        end
    endtask

    task automatic do_reset();
        rx_i    = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        sb_q.delete();
        wr_seen = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // write monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && imem_we_o) begin
            wr_seen++;
            check("we_one_cycle", prev_we, 1'b0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none", imem_addr_o, imem_wdata_o);
            end else begin
                check("write", {32'(imem_addr_o), imem_wdata_o}, sb_q.pop_front());
            end
        end
        prev_we = imem_we_o;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad_cnt;
        int   cyc;
        logic [7:0] cs;

        add("prog2", 11, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00},
            -1, 3, 11, 2, 32'h00000013, 32'h00100093, 1'b1, 1'b0);
        add("garbage_hdr", 9, {8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
            -1, 5, 9, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        add("stop_err", 12, {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04},
            4, -1, -1, 0, 32'h0, 32'h0, 1'b0, 1'b1);
        add("len513", 3, {8'hA5, 8'h01, 8'h02}, -1, -1, -1, 0, 32'h0, 32'h0, 1'b0, 1'b1);
        add("len0", 3, {8'hA5, 8'h00, 8'h00}, -1, 3, 3, 0, 32'h0, 32'h0, 1'b1, 1'b0);
        add("len512", 3, {8'hA5, 8'h00, 8'h02}, -1, -1, -1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        add("hdr_frame_err", 2, {8'h00, 8'hA5}, 0, -1, -1, 0, 32'h0, 32'h0, 1'b0, 1'b1);
        add("terminal", 14, {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44},
            -1, 3, 7, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);

        // reset values, then core held in reset while idle
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", imem_we_o, 1'b0);
        check("rst_addr", imem_addr_o, 0);
        check("rst_wdata", imem_wdata_o, 0);
        check("rst_core_reset_n", core_reset_n_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        bad_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (core_reset_n_o || done_o || err_o || imem_we_o) bad_cnt++;
        end
        check("idle_1000_core_in_reset", bad_cnt, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            do_reset();
            if (vecs[k].nwr > 0) sb_q.push_back({32'd0, vecs[k].w0});
            if (vecs[k].nwr > 1) sb_q.push_back({32'd1, vecs[k].w1});
            send_frame(vecs[k]);
            repeat (40) @(posedge clk);
            #1;
            check({vecs[k].name, ":done"}, done_o, vecs[k].exp_done);
            check({vecs[k].name, ":err"}, err_o, vecs[k].exp_err);
            check({vecs[k].name, ":core_reset_n"}, core_reset_n_o, vecs[k].exp_done);
            check({vecs[k].name, ":writes"}, wr_seen, vecs[k].nwr);
            check({vecs[k].name, ":sb_empty"}, sb_q.size(), 0);
        end

        // short low glitch between payload bytes must not produce a byte
        do_reset();
        sb_q.push_back({32'd0, 32'hDEADBEEF});
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1);
        @(posedge clk); #1 rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch:err", err_o, 1'b0);
        send_byte(8'hDE, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        cs = 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
        send_byte(cs, 1'b1);
`endif
        repeat (40) @(posedge clk);
        #1;
        check("glitch:done", done_o, 1'b1);
        check("glitch:writes", wr_seen, 1);

        // done latency from the start edge of the final byte
        do_reset();
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        cyc = 0;
        fork
            send_byte(8'h00, 1'b1);
            begin
                @(posedge clk); #1;
                while (!done_o && cyc < 400) begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        check("done_latency", cyc, 9 * CPB + CPB / 2 + 3);
        check("latency:core_reset_n", core_reset_n_o, 1'b1);

        // reset during DATA discards the partial word; address 0 is reused
        do_reset();
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        check("midreset:no_write", wr_seen, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset:addr", imem_addr_o, 0);
        check("midreset:core_reset_n", core_reset_n_o, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back({32'd0, 32'hCAFEF00D});
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'hCA, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        cs = 8'h0D ^ 8'hF0 ^ 8'hFE ^ 8'hCA;
        send_byte(cs, 1'b1);
`endif
        repeat (40) @(posedge clk);
        #1;
        check("midreset:done", done_o, 1'b1);
        check("midreset:writes", wr_seen, 1);
        check("midreset:sb_empty", sb_q.size(), 0);

`ifdef BOOT_CHECKSUM_EN
        // wrong checksum: the word is still written, then error
        do_reset();
        sb_q.push_back({32'd0, 32'h12345678});
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        cs = (8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12) ^ 8'h01;
        send_byte(cs, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("badcsum:err", err_o, 1'b1);
        check("badcsum:done", done_o, 1'b0);
        check("badcsum:core_reset_n", core_reset_n_o, 1'b0);
        check("badcsum:writes", wr_seen, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
